// File: rtl/opcode_pkg.sv
// Purpose: shared operation codes and keypad key codes for the opcode decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package opcode_pkg;

  localparam int KEY_W = 4;
  localparam int OP_W  = 2;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_ENTER = 2'b11
  } op_t;

  localparam logic [KEY_W-1:0] KEY_NOP   = 4'b1010;
  localparam logic [KEY_W-1:0] KEY_ADD   = 4'b1011;
  localparam logic [KEY_W-1:0] KEY_SUB   = 4'b1100;
  localparam logic [KEY_W-1:0] KEY_ENTER = 4'b1101;

endpackage

// File: rtl/strobe_edge_detect.sv
// Purpose: synchronise an asynchronous level into clk and flag its rising edge.
// Latency: rise_pulse is high SYNC_STAGES edges after async_in rises, for one cycle.
// Backpressure: none; a level held high yields exactly one pulse.
module strobe_edge_detect #(
  parameter int SYNC_STAGES = 2  // 2 or 3 stages
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus one flop of history for the edge detector; all clear to 0
  // so a level held high through reset release still produces one edge afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/opcode_decoder.sv
// Purpose: decode keypad code to operation code; capture operations on key-strobe edges.
// Latency: out/is_op combinational; op_strobe SYNC_STAGES+1 edges after key_strobe rises.
// Backpressure: none; in must hold from key_strobe rise until op_strobe.
module opcode_decoder
  import opcode_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KEY_W-1:0] in,
  input  logic            key_strobe,
  output logic [OP_W-1:0] out,
  output logic            is_op,
  output logic            op_strobe,
  output logic [OP_W-1:0] last_op,
  output logic            last_op_valid
);

  op_t  w_op;
  logic w_is_op;
  logic w_rise;
  logic r_op_strobe;
  op_t  r_last_op;
  logic r_last_op_valid;

  // Pure decode of the key code; stays live during reset and ignores the clock.
  always_comb begin
    w_op    = OP_NOP;
    w_is_op = 1'b0;
    case (in)
      KEY_NOP:   begin w_op = OP_NOP;   w_is_op = 1'b1; end
      KEY_ADD:   begin w_op = OP_ADD;   w_is_op = 1'b1; end
      KEY_SUB:   begin w_op = OP_SUB;   w_is_op = 1'b1; end
      KEY_ENTER: begin w_op = OP_ENTER; w_is_op = 1'b1; end
      default:   begin w_op = OP_NOP;   w_is_op = 1'b0; end
    endcase
  end

  assign out   = w_op;
  assign is_op = w_is_op;

  strobe_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .async_in  (key_strobe),
    .rise_pulse(w_rise)
  );

  // Capture the decoded operation on a strobe edge; digit/invalid keys leave state untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_strobe     <= 1'b0;
      r_last_op       <= OP_NOP;
      r_last_op_valid <= 1'b0;
    end else begin
      r_op_strobe <= w_rise & w_is_op;
      if (w_rise && w_is_op) begin
        r_last_op       <= w_op;
        r_last_op_valid <= 1'b1;
      end
    end
  end

  assign op_strobe     = r_op_strobe;
  assign last_op       = r_last_op;
  assign last_op_valid = r_last_op_valid;

endmodule

// File: tb/tb_opcode_decoder.sv
// Purpose: self-checking bench for opcode_decoder (decode table plus strobe sequences).
// Latency: checks op_strobe lands exactly 3 edges after a key_strobe rise.
// Backpressure: n/a.
module tb_opcode_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic       key_strobe;
  logic [1:0] out;
  logic       is_op;
  logic       op_strobe;
  logic [1:0] last_op;
  logic       last_op_valid;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] code;
    logic [1:0] exp_out;
    logic       exp_is_op;
  } vec_t;

  vec_t vecs[16];

  opcode_decoder #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (key_in),
    .key_strobe   (key_strobe),
    .out          (out),
    .is_op        (is_op),
    .op_strobe    (op_strobe),
    .last_op      (last_op),
    .last_op_valid(last_op_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every op_strobe pulse must match the oldest expected capture.
  always @(negedge clk) begin
    if (op_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_op_strobe", 32'(op_strobe), 32'd0);
      end else begin
        chk("sb_last_op", 32'(last_op), 32'(exp_q.pop_front()));
        chk("sb_last_op_valid", 32'(last_op_valid), 32'd1);
      end
    end
  end

  // Raise key_strobe with a key present and check op_strobe timing edge by edge.
  task automatic press(input logic [3:0] code, input logic expect_op, input logic [1:0] exp_op);
    @(negedge clk);
    key_in     = code;
    key_strobe = 1'b1;
    if (expect_op) exp_q.push_back(exp_op);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("press_%0h_edge%0d", code, k), 32'(op_strobe),
          32'((expect_op && k == 3) ? 1 : 0));
    end
  endtask

  task automatic release_strobe(input int cycles);
    @(negedge clk);
    key_strobe = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b0;
    key_strobe = 1'b0;
    key_in     = 4'd0;

    for (int i = 0; i < 16; i++) begin
      vecs[i].code      = 4'(i);
      vecs[i].exp_out   = 2'b00;
      vecs[i].exp_is_op = 1'b0;
    end
    vecs[10] = '{4'b1010, 2'b00, 1'b1};
    vecs[11] = '{4'b1011, 2'b01, 1'b1};
    vecs[12] = '{4'b1100, 2'b10, 1'b1};
    vecs[13] = '{4'b1101, 2'b11, 1'b1};

    #3;
    chk("rst_op_strobe", 32'(op_strobe), 32'd0);
    chk("rst_last_op", 32'(last_op), 32'd0);
    chk("rst_last_op_valid", 32'(last_op_valid), 32'd0);

    // Decode table swept with reset held: operations first, then 1111, 1110, 0000..1001.
    for (int j = 0; j < 16; j++) begin
      int idx;
      idx = (j < 4) ? (10 + j) : (j < 6) ? (15 - (j - 4)) : (j - 6);
      key_in = vecs[idx].code;
      #50;
      chk($sformatf("decode_out_%0h", vecs[idx].code), 32'(out), 32'(vecs[idx].exp_out));
      chk($sformatf("decode_is_op_%0h", vecs[idx].code), 32'(is_op), 32'(vecs[idx].exp_is_op));
    end

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // SUB capture with exact latency.
    press(4'b1100, 1'b1, 2'b10);
    chk("sub_last_op", 32'(last_op), 32'd2);
    chk("sub_last_op_valid", 32'(last_op_valid), 32'd1);

    // Held high: no further pulses.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("held_no_pulse", 32'(op_strobe), 32'd0);
    end
    release_strobe(3);

    // Digit key on a fresh edge: nothing captured.
    press(4'b0101, 1'b0, 2'b00);
    chk("digit_last_op", 32'(last_op), 32'd2);
    chk("digit_last_op_valid", 32'(last_op_valid), 32'd1);
    release_strobe(3);

    // Back-to-back ADD then ENTER.
    press(4'b1011, 1'b1, 2'b01);
    chk("add_last_op", 32'(last_op), 32'd1);
    release_strobe(3);
    press(4'b1101, 1'b1, 2'b11);
    chk("enter_last_op", 32'(last_op), 32'd3);
    release_strobe(3);

    // Reset mid-event: edge pending when reset hits, strobe dropped before release.
    @(negedge clk);
    key_in     = 4'b1101;
    key_strobe = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_op_strobe", 32'(op_strobe), 32'd0);
    chk("midrst_last_op", 32'(last_op), 32'd0);
    chk("midrst_last_op_valid", 32'(last_op_valid), 32'd0);
    key_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_pulse", 32'(op_strobe), 32'd0);
    end
    chk("post_rst_last_op_valid", 32'(last_op_valid), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
